// File: rtl/trap_commit_unit_pkg.sv
// Shared CSR/trap types for the writeback trap sequencer.
// Exception pack layout, CSR addresses, mstatus fields, FSM states.
package trap_commit_unit_pkg;

  localparam int CSR_XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [CSR_XLEN-1:0] CAUSE_ILLEGAL = 64'd2;

  typedef struct packed {
    logic                except;
    logic [CSR_XLEN-1:0] epc;
    logic [CSR_XLEN-1:0] ecause;
    logic [CSR_XLEN-1:0] etval;
  } except_pack_t;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STATUS,
    R_STATUS,
    REDIRECT
  } trap_state_t;

endpackage

// File: rtl/trap_commit_unit_target_calc.sv
// Trap entry address from mtvec: direct or vectored
// (vectored only for interrupts, i.e. cause MSB set).
module trap_target_calc
  import trap_commit_unit_pkg::*;
#(
  parameter int XLEN = CSR_XLEN
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offs;
  logic            vec;

  always_comb begin
    base   = {mtvec[XLEN-1:2], 2'b00};
    offs   = XLEN'({1'b0, cause[XLEN-2:0]}) << 2;
    vec    = (mtvec[1:0] == 2'b01) && cause[XLEN-1];
    target = vec ? base + offs : base;
  end

endmodule

// File: rtl/trap_commit_unit.sv
// WB-stage trap/MRET commit: serialises M-mode CSR updates,
// flushes the pipe, redirects fetch and owns the privilege level.
module trap_commit_unit
  import trap_commit_unit_pkg::*;
#(
  parameter int         XLEN       = CSR_XLEN,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_wb,
  input  except_pack_t    except_wb,
  input  logic            mret_wb,
  input  logic [XLEN-1:0] pc_wb,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic [1:0]      priv_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  trap_state_t     state;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic            mret_q;

  logic            take_trap;
  logic            take_mret;
  logic            bad_mret;
  logic            detect;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] st_trap;
  logic [XLEN-1:0] st_mret;

  assign take_trap = valid_wb & except_wb.except;
  assign take_mret = valid_wb & mret_wb
                   & ~except_wb.except & (priv_o == PRIV_M);
  assign bad_mret  = valid_wb & mret_wb
                   & ~except_wb.except & (priv_o != PRIV_M);
  assign detect    = rst & (state == IDLE)
                   & (take_trap | take_mret | bad_mret);

  trap_target_calc #(.XLEN(XLEN)) u_target (
    .mtvec  (mtvec_i),
    .cause  (cause_q),
    .target (trap_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      priv_o  <= RESET_PRIV;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      mret_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            take_trap: begin
              state   <= T_EPC;
              epc_q   <= except_wb.epc;
              cause_q <= except_wb.ecause;
              tval_q  <= except_wb.etval;
              mret_q  <= 1'b0;
            end
            bad_mret: begin
              state   <= T_EPC;
              epc_q   <= pc_wb;
              cause_q <= CAUSE_ILLEGAL;
              tval_q  <= '0;
              mret_q  <= 1'b0;
            end
            take_mret: begin
              state   <= R_STATUS;
              mret_q  <= 1'b1;
            end
            default: ;
          endcase
        end
        T_EPC:    state <= T_CAUSE;
        T_CAUSE:  state <= T_TVAL;
        T_TVAL:   state <= T_STATUS;
        T_STATUS: begin
          priv_o <= PRIV_M;
          state  <= REDIRECT;
        end
        R_STATUS: begin
          priv_o <= mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          state  <= REDIRECT;
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    st_trap = mstatus_i;
    st_trap[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
    st_trap[MSTATUS_MIE]  = 1'b0;
    st_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_o;
    st_mret = mstatus_i;
    st_mret[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
    st_mret[MSTATUS_MPIE] = 1'b1;
    st_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  always_comb begin
    csr_we_o      = 1'b0;
    csr_waddr_o   = '0;
    csr_wdata_o   = '0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    flush_o       = detect | (state != IDLE);
    stall_o       = detect | (state != IDLE);
    unique case (state)
      T_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_q;
      end
      T_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      T_TVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MTVAL;
        csr_wdata_o = tval_q;
      end
      T_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = st_trap;
      end
      R_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = st_mret;
      end
      REDIRECT: begin
        redirect_o    = 1'b1;
        redirect_pc_o = mret_q ? {mepc_i[XLEN-1:1], 1'b0}
                               : trap_pc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_commit_unit.sv
// Directed bench for trap_commit_unit: trap, MRET, vectored,
// illegal MRET, priority, mid-sequence input and reset cases.
module tb_trap_commit_unit;
  import trap_commit_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_wb;
  except_pack_t except_wb;
  logic         mret_wb;
  logic [63:0]  pc_wb, mtvec_i, mepc_i, mstatus_i;
  logic         csr_we_o;
  logic [11:0]  csr_waddr_o;
  logic [63:0]  csr_wdata_o;
  logic [1:0]   priv_o;
  logic         flush_o, stall_o, redirect_o;
  logic [63:0]  redirect_pc_o;

  int total = 0;
  int fails = 0;

  trap_commit_unit dut (
    .clk           (clk),
    .rst           (rst),
    .valid_wb      (valid_wb),
    .except_wb     (except_wb),
    .mret_wb       (mret_wb),
    .pc_wb         (pc_wb),
    .mtvec_i       (mtvec_i),
    .mepc_i        (mepc_i),
    .mstatus_i     (mstatus_i),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .priv_o        (priv_o),
    .flush_o       (flush_o),
    .stall_o       (stall_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic we,
                     input logic [11:0] addr, input logic [63:0] data,
                     input logic fl, input logic rd,
                     input logic [63:0] rpc);
    chk({tag, ".we"},    64'(csr_we_o),      64'(we));
    chk({tag, ".addr"},  64'(csr_waddr_o),   64'(addr));
    chk({tag, ".data"},  csr_wdata_o,        data);
    chk({tag, ".flush"}, 64'(flush_o),       64'(fl));
    chk({tag, ".stall"}, 64'(stall_o),       64'(fl));
    chk({tag, ".redir"}, 64'(redirect_o),    64'(rd));
    chk({tag, ".rpc"},   redirect_pc_o,      rpc);
  endtask

  task automatic adv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in;
    valid_wb  = 1'b0;
    mret_wb   = 1'b0;
    except_wb = '0;
  endtask

  // Drives one WB event at the current negedge and walks the trap path.
  task automatic run_trap(
    input string tag, input logic ex, input logic mr,
    input logic [63:0] epc, input logic [63:0] cause,
    input logic [63:0] tval, input logic inject,
    input logic [63:0] x_epc, input logic [63:0] x_cause,
    input logic [63:0] x_tval, input logic [63:0] x_status,
    input logic [1:0] x_priv0, input logic [63:0] x_pc);
    valid_wb  = 1'b1;
    mret_wb   = mr;
    except_wb = '{except: ex, epc: epc, ecause: cause, etval: tval};
    #1 cyc({tag, ".det"}, 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    adv; idle_in;
    #1 cyc({tag, ".epc"}, 1'b1, 12'h341, x_epc, 1'b1, 1'b0, 64'h0);
    adv;
    if (inject) begin
      valid_wb  = 1'b1;
      except_wb = '{except: 1'b1, epc: 64'hdead, ecause: 64'd5,
                    etval: 64'hbeef};
    end
    #1 cyc({tag, ".cause"}, 1'b1, 12'h342, x_cause, 1'b1, 1'b0,
           64'h0);
    adv; idle_in;
    #1 cyc({tag, ".tval"}, 1'b1, 12'h343, x_tval, 1'b1, 1'b0, 64'h0);
    adv;
    #1 cyc({tag, ".stat"}, 1'b1, 12'h300, x_status, 1'b1, 1'b0,
           64'h0);
    chk({tag, ".priv0"}, 64'(priv_o), 64'(x_priv0));
    adv;
    #1 cyc({tag, ".redir"}, 1'b0, 12'h0, 64'h0, 1'b1, 1'b1, x_pc);
    chk({tag, ".priv1"}, 64'(priv_o), 64'(2'b11));
    adv;
    #1 cyc({tag, ".done"}, 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    rst = 1'b0;
    idle_in;
    pc_wb     = 64'h0;
    mtvec_i   = 64'h8000_0100;
    mepc_i    = 64'h0;
    mstatus_i = 64'h8;
    valid_wb  = 1'b1;
    except_wb.except = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 cyc("rst", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk("rst.priv", 64'(priv_o), 64'd3);
    idle_in;
    @(negedge clk);
    rst = 1'b1;
    #1 cyc("post_rst", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk("post_rst.priv", 64'(priv_o), 64'd3);
    adv;

    run_trap("ecall", 1'b1, 1'b0, 64'h8000_0010, 64'd11, 64'h0,
             1'b0, 64'h8000_0010, 64'd11, 64'h0, 64'h1880, 2'b11,
             64'h8000_0100);

    run_trap("illegal", 1'b1, 1'b0, 64'h8000_0020, 64'd2, 64'h1234,
             1'b0, 64'h8000_0020, 64'd2, 64'h1234, 64'h1880, 2'b11,
             64'h8000_0100);

    mstatus_i = 64'h80;
    mepc_i    = 64'h8000_0201;
    valid_wb  = 1'b1;
    mret_wb   = 1'b1;
    #1 cyc("mret.det", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    adv; idle_in;
    #1 cyc("mret.stat", 1'b1, 12'h300, 64'h88, 1'b1, 1'b0, 64'h0);
    chk("mret.priv0", 64'(priv_o), 64'd3);
    adv;
    #1 cyc("mret.redir", 1'b0, 12'h0, 64'h0, 1'b1, 1'b1,
           64'h8000_0200);
    chk("mret.priv1", 64'(priv_o), 64'd0);
    adv;
    #1 cyc("mret.done", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);

    mstatus_i = 64'h8;
    pc_wb     = 64'h8000_0300;
    run_trap("badmret", 1'b0, 1'b1, 64'h1111, 64'd9, 64'h77,
             1'b0, 64'h8000_0300, 64'd2, 64'h0, 64'h80, 2'b00,
             64'h8000_0100);

    valid_wb  = 1'b0;
    mret_wb   = 1'b1;
    except_wb = '{except: 1'b1, epc: 64'h1, ecause: 64'h2,
                  etval: 64'h3};
    #1 cyc("novalid.0", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    adv;
    #1 cyc("novalid.1", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    idle_in;

    run_trap("both", 1'b1, 1'b1, 64'h8000_0400, 64'd3, 64'h55,
             1'b0, 64'h8000_0400, 64'd3, 64'h55, 64'h1880, 2'b11,
             64'h8000_0100);

    mtvec_i = 64'h8000_0101;
    run_trap("vect", 1'b1, 1'b0, 64'h8000_0500,
             64'h8000_0000_0000_0007, 64'h0, 1'b1, 64'h8000_0500,
             64'h8000_0000_0000_0007, 64'h0, 64'h1880, 2'b11,
             64'h8000_011C);

    run_trap("vect_exc", 1'b1, 1'b0, 64'h8000_0600, 64'd7, 64'h0,
             1'b0, 64'h8000_0600, 64'd7, 64'h0, 64'h1880, 2'b11,
             64'h8000_0100);
    mtvec_i = 64'h8000_0100;

    valid_wb  = 1'b1;
    except_wb = '{except: 1'b1, epc: 64'h8000_0700, ecause: 64'd4,
                  etval: 64'h99};
    #1 cyc("rstmid.det", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    adv; idle_in;
    adv; adv;
    #1 cyc("rstmid.tval", 1'b1, 12'h343, 64'h99, 1'b1, 1'b0, 64'h0);
    rst = 1'b0;
    #1 cyc("rstmid.rst", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk("rstmid.priv", 64'(priv_o), 64'd3);
    adv;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 cyc("rstmid.after", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
      adv;
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
